pipelined_variable_right_shifter: RTL and testbench

Pipelined logarithmic right shifter: shifts an N-bit word right by a per-transaction amount 0..N-1 through log2(N) registered stages, each stage conditionally applying a fixed right shift by 2^k. It sits directly downstream of the fixed-amount right-shift units and feeds the datapath consumer over a valid/ready stream. It sustains one transaction per cycle and collapses pipeline bubbles under backpressure.

---
 rtl/pipelined_variable_right_shifter_if.sv | 75 +++++++
 rtl/pipelined_variable_right_shifter.sv | 169 ++++++++++++++++
 tb/tb_pipelined_variable_right_shifter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_variable_right_shifter_if.sv
// ---------------------------------------------------------------------------
// pipelined_variable_right_shifter_if
//
// Purpose:
//   This interface bundles the two valid/ready streams around the pipelined
//   variable right shifter. The upstream side carries the word to shift and
//   the shift amount. The downstream side carries the shifted result.
//
// Parameters:
//   N   data width (power of two, >= 2)
//   SW  shift-amount width, $clog2(N)
//
// Signals:
//   up_valid    producer has a word for the shifter
//   up_ready    shifter accepts the word this cycle
//   up_data     word to shift (N bits)
//   up_shamt    unsigned right-shift amount (SW bits)
//   up_arith    present only when PVRS_ARITH_EN is defined;
//               1 = sign-fill, 0 = zero-fill
//   down_valid  shifter presents a result
//   down_ready  consumer accepts the result
//   down_data   shifted result (N bits)
//
// Modports:
//   master  the surrounding environment (producer plus consumer)
//   slave   the shifter itself
//
// Configuration macro: PVRS_ARITH_EN adds the up_arith signal.
// ---------------------------------------------------------------------------
interface pipelined_variable_right_shifter_if #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
);

  logic          up_valid;
  logic          up_ready;
  logic [N-1:0]  up_data;
  logic [SW-1:0] up_shamt;
`ifdef PVRS_ARITH_EN
  logic          up_arith;
`endif
  logic          down_valid;
  logic          down_ready;
  logic [N-1:0]  down_data;

  // The environment drives the upstream payload and the downstream ready,
  // and it observes everything the shifter produces.
  modport master (
    output up_valid,
    output up_data,
    output up_shamt,
`ifdef PVRS_ARITH_EN
    output up_arith,
`endif
    input  up_ready,
    input  down_valid,
    input  down_data,
    output down_ready
  );

  // The shifter sees the mirror image of the environment's view.
  modport slave (
    input  up_valid,
    input  up_data,
    input  up_shamt,
`ifdef PVRS_ARITH_EN
    input  up_arith,
`endif
    output up_ready,
    output down_valid,
    output down_data,
    input  down_ready
  );

endinterface

// File: rtl/pipelined_variable_right_shifter.sv
// ---------------------------------------------------------------------------
// pipelined_variable_right_shifter
//
// Purpose:
//   This is a logarithmic right shifter split into SW registered stages.
//   Stage k conditionally shifts its word right by 2^k, depending on bit k of
//   the shift amount. The block accepts one transaction per cycle. Under
//   backpressure it collapses bubbles, so it can hold up to SW words before
//   it deasserts up_ready.
//
// Parameters:
//   N   data width (power of two, >= 2), default 8
//   SW  stage count and shift-amount width, $clog2(N)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; it empties every stage at once
//   bus    pipelined_variable_right_shifter_if.slave. It carries:
//            up_valid / up_ready / up_data / up_shamt [/ up_arith]
//            down_valid / down_ready / down_data
//
// Configuration macro:
//   PVRS_ARITH_EN
//     When defined, the up_arith input exists. Each stage then carries an
//     arith flag and the word's original MSB, and up_arith = 1 fills the
//     vacated bits with that MSB.
//     When undefined, the block is a pure logical (zero-fill) shifter.
// ---------------------------------------------------------------------------
module pipelined_variable_right_shifter #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  pipelined_variable_right_shifter_if.slave    bus
);

  // Only the first SW-1 stages need to carry shift-amount bits forward. The
  // last stage consumes the final bit and keeps nothing. RW is the width of
  // that remainder and also the number of stages that store one. It is
  // clamped to 1 so the declarations stay legal when N = 2.
  localparam int RW = (SW > 1) ? SW - 1 : 1;

  // Per-stage registered state
  logic [SW-1:0] v;
  logic [N-1:0]  d   [SW];
  logic [RW-1:0] rem [RW];
`ifdef PVRS_ARITH_EN
  logic [RW-1:0] ar_q;
  logic [RW-1:0] msb_q;
`endif

  // Per-stage inputs: from the upstream port for stage 0, otherwise from
  // the previous stage.
  logic [SW-1:0] rdy;
  logic [SW-1:0] in_v;
  logic [SW-1:0] in_sel;
  logic [N-1:0]  in_d   [SW];
  logic [N-1:0]  nxt_d  [SW];
  logic [RW-1:0] in_rem [RW];
`ifdef PVRS_ARITH_EN
  logic [SW-1:0] in_ar;
  logic [SW-1:0] in_msb;
`endif

  // Ready chain. A stage may load when it is empty or when everything
  // downstream of it can move. This is equivalent to the stage-by-stage
  // recurrence rdy[k] = !v[k] || rdy[k+1], but it is written as a
  // top-down accumulation so that no vector signal feeds back into itself.
  // A full pipeline with down_ready high therefore still accepts a new word
  // in the same cycle as the output transfer.
  always_comb begin
    logic acc;
    rdy = '0;
    acc = bus.down_ready;
    for (int k = SW - 1; k >= 0; k--) begin
      acc    = acc | ~v[k];
      rdy[k] = acc;
    end
  end

  // Stage wiring and shift datapath. The remaining shift-amount bits are
  // kept right-aligned. Each stage therefore tests bit 0 of what it
  // receives and forwards the rest shifted down by one. This keeps every
  // remainder register the same width regardless of stage index.
  for (genvar k = 0; k < SW; k++) begin : g_stage
    localparam int           AMT       = 1 << k;
    localparam logic [N-1:0] FILL_MASK = ~({N{1'b1}} >> AMT);

    if (k == 0) begin : g_src
      assign in_v[k]   = bus.up_valid;
      assign in_d[k]   = bus.up_data;
      assign in_sel[k] = bus.up_shamt[0];
`ifdef PVRS_ARITH_EN
      assign in_ar[k]  = bus.up_arith;
      assign in_msb[k] = bus.up_data[N-1];
`endif
    end else begin : g_src
      assign in_v[k]   = v[k-1];
      assign in_d[k]   = d[k-1];
      assign in_sel[k] = rem[k-1][0];
`ifdef PVRS_ARITH_EN
      assign in_ar[k]  = ar_q[k-1];
      assign in_msb[k] = msb_q[k-1];
`endif
    end

    if (k < SW - 1) begin : g_rem
      if (k == 0) begin : g_first
        assign in_rem[k] = bus.up_shamt[SW-1:1];
      end else begin : g_next
        assign in_rem[k] = rem[k-1] >> 1;
      end
    end

`ifdef PVRS_ARITH_EN
    // Sign fill ORs the original MSB into the vacated top AMT bits.
    assign nxt_d[k] = in_sel[k]
                    ? ((in_d[k] >> AMT) | ((in_ar[k] & in_msb[k]) ? FILL_MASK : '0))
                    : in_d[k];
`else
    assign nxt_d[k] = in_sel[k] ? (in_d[k] >> AMT) : in_d[k];
`endif
  end

  // Pipeline registers. A stage whose ready is high captures whatever its
  // predecessor offers, including a bubble (valid = 0). Otherwise it holds
  // its contents, which keeps down_valid and down_data stable while the
  // consumer stalls. Reset is asynchronous, so in-flight words disappear as
  // soon as rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int k = 0; k < SW; k++) begin
        d[k] <= '0;
      end
      for (int k = 0; k < RW; k++) begin
        rem[k] <= '0;
      end
`ifdef PVRS_ARITH_EN
      ar_q  <= '0;
      msb_q <= '0;
`endif
    end else begin
      for (int k = 0; k < SW; k++) begin
        if (rdy[k]) begin
          v[k] <= in_v[k];
          d[k] <= nxt_d[k];
        end
      end
      for (int k = 0; k < SW - 1; k++) begin
        if (rdy[k]) begin
          rem[k] <= in_rem[k];
`ifdef PVRS_ARITH_EN
          ar_q[k]  <= in_ar[k];
          msb_q[k] <= in_msb[k];
`endif
        end
      end
    end
  end

  // The down_* outputs come straight from the last stage's registers.
  // up_ready is the head of the combinational ready chain.
  assign bus.up_ready   = rdy[0];
  assign bus.down_valid = v[SW-1];
  assign bus.down_data  = d[SW-1];

endmodule

// File: tb/tb_pipelined_variable_right_shifter.sv
// ---------------------------------------------------------------------------
// tb_pipelined_variable_right_shifter
//
// Purpose:
//   This is a scoreboard bench for pipelined_variable_right_shifter (N = 8).
//   The driver pushes the reference result for each accepted word into a
//   queue. An independent monitor pops one entry per downstream transfer and
//   compares it with the DUT output. The monitor also checks that a stalled
//   output holds its value. The reference result is simply the >> operator,
//   or >>> on a signed view of the word when arith mode is selected.
//
// Configuration macro: PVRS_ARITH_EN enables the arith-mode checks.
// ---------------------------------------------------------------------------
module tb_pipelined_variable_right_shifter;

  localparam int N  = 8;
  localparam int SW = $clog2(N);
`ifdef PVRS_ARITH_EN
  localparam bit ARITH = 1'b1;
`else
  localparam bit ARITH = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int total     = 0;
  int bad       = 0;
  int transfers = 0;
  int cycle     = 0;
  bit randReady = 1'b0;
  bit holdValid = 1'b0;
  logic [N-1:0] holdData = '0;
  logic [N-1:0] expQ[$];
  int outCycle[$];

  always #5 clk = ~clk;

  pipelined_variable_right_shifter_if #(.N(N), .SW(SW)) bus ();

  pipelined_variable_right_shifter #(.N(N), .SW(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running cycle count. The bench uses it to check that a
  // back-to-back stream leaves on consecutive cycles.
  always @(posedge clk) cycle++;

  // Reference model: the plain shift operators.
  function automatic logic [N-1:0] refShift(input logic [N-1:0] data,
                                            input int sh, input bit ar);
    logic signed [N-1:0] s;
    s = data;
    if (ar) return s >>> sh;
    return data >> sh;
  endfunction

  // Records one comparison. On a mismatch it prints the actual and the
  // required value.
  task automatic checkOutput(input string name, input logic [N-1:0] actual,
                             input logic [N-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Presents one word and holds it until the DUT accepts it.
  // - The acceptance decision is sampled just after the falling edge, when
  //   every input is already settled.
  // - The expected result is queued only for the word that is actually
  //   taken.
  // - In randReady mode, down_ready is re-randomised every cycle.
  task automatic applyStimulus(input logic [N-1:0] data,
                               input logic [SW-1:0] sh, input bit ar);
    int  waited = 0;
    bit  done   = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (randReady) bus.down_ready = ($urandom_range(0, 3) != 0);
      bus.up_valid = 1'b1;
      bus.up_data  = data;
      bus.up_shamt = sh;
`ifdef PVRS_ARITH_EN
      bus.up_arith = ar;
`endif
      #1;
      if (bus.up_ready) begin
        expQ.push_back(refShift(data, int'(sh), ar));
        done = 1'b1;
      end else if (++waited > 100) begin
        total++;
        bad++;
        $display("[TB] FAIL accept_timeout: up_ready stayed 0, expected 1 within 100 cycles");
        done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    bus.up_valid = 1'b0;
  endtask

  // Releases backpressure and waits, for a bounded time, until every queued
  // result has left the DUT.
  task automatic waitDrain();
    int n = 0;
    @(negedge clk);
    bus.down_ready = 1'b1;
    while ((expQ.size() != 0 || bus.down_valid) && n < 200) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (expQ.size() != 0 || bus.down_valid) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout: %0d results outstanding, expected 0", expQ.size());
    end
  endtask

  // Monitor: runs on the falling edge, clear of the driver's settle point.
  // - A downstream handshake pops and compares the next expected result.
  // - A stalled valid output is remembered, so the next sample can check
  //   that it did not change.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      holdValid = 1'b0;
    end else begin
      if (holdValid) begin
        checkOutput("hold_valid", N'(bus.down_valid), N'(1));
        checkOutput("hold_data", bus.down_data, holdData);
      end
      if (bus.down_valid && bus.down_ready) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL spurious_output: got %h, expected no transfer", bus.down_data);
        end else begin
          checkOutput("result", bus.down_data, expQ.pop_front());
        end
        transfers++;
        outCycle.push_back(cycle);
        holdValid = 1'b0;
      end else if (bus.down_valid) begin
        holdValid = 1'b1;
        holdData  = bus.down_data;
      end else begin
        holdValid = 1'b0;
      end
    end
  end

  // Watchdog, in case the stimulus process itself ever hangs.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios first, then a randomised stream with random
  // backpressure.
  initial begin
    int startT;
    int first;
    int acc;
    logic [N-1:0] bpData [3];

    bus.up_valid   = 1'b0;
    bus.up_data    = '0;
    bus.up_shamt   = '0;
`ifdef PVRS_ARITH_EN
    bus.up_arith   = 1'b0;
`endif
    bus.down_ready = 1'b0;

    // Reset values while in reset, and again after release with no traffic.
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_down_valid", N'(bus.down_valid), '0);
    checkOutput("rst_down_data", bus.down_data, 8'h00);
    checkOutput("rst_up_ready", N'(bus.up_ready), N'(1));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("idle_down_valid", N'(bus.down_valid), '0);
    checkOutput("idle_down_data", bus.down_data, 8'h00);
    checkOutput("idle_up_ready", N'(bus.up_ready), N'(1));

    // Single transaction. Valid must appear after the third edge, with
    // exactly one transfer.
    @(negedge clk);
    bus.down_ready = 1'b1;
    startT = transfers;
    applyStimulus(8'hB4, 3'd3, 1'b0);
    @(negedge clk); #1;
    checkOutput("lat_edge1_valid", N'(bus.down_valid), '0);
    @(negedge clk); #1;
    checkOutput("lat_edge2_valid", N'(bus.down_valid), '0);
    @(negedge clk); #1;
    checkOutput("lat_edge3_valid", N'(bus.down_valid), N'(1));
    checkOutput("lat_edge3_data", bus.down_data, 8'h16);
    repeat (4) @(negedge clk);
    checkOutput("single_transfers", N'(transfers - startT), N'(1));

    // Back-to-back stream of 8'hFF with shift amounts 0..7. The results must
    // leave on consecutive cycles.
    first = outCycle.size();
    for (int s = 0; s < N; s++) applyStimulus(8'hFF, SW'(s), 1'b0);
    waitDrain();
    checkOutput("stream_count", N'(outCycle.size() - first), N'(N));
    if (outCycle.size() - first == N)
      checkOutput("stream_span", N'(outCycle[first + N - 1] - outCycle[first]), N'(N - 1));

    // Backpressure: offer words for 6 cycles while the consumer stalls.
    // Exactly 3 words are taken before up_ready falls.
    for (int i = 0; i < 3; i++) bpData[i] = N'($urandom);
    @(negedge clk);
    bus.down_ready = 1'b0;
    startT = transfers;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      bus.up_valid = 1'b1;
      bus.up_data  = bpData[acc < 3 ? acc : 2];
      bus.up_shamt = SW'(acc + 1);
`ifdef PVRS_ARITH_EN
      bus.up_arith = 1'b0;
`endif
      #1;
      if (bus.up_ready) begin
        expQ.push_back(refShift(bus.up_data, int'(bus.up_shamt), 1'b0));
        acc++;
      end
    end
    @(negedge clk);
    bus.up_valid = 1'b0;
    #1;
    checkOutput("bp_accepted", N'(acc), N'(3));
    checkOutput("bp_up_ready", N'(bus.up_ready), '0);
    waitDrain();
    checkOutput("bp_drained", N'(transfers - startT), N'(3));

    // Reset with two words in flight. down_valid must drop at once, and the
    // next word afterwards must come out correctly.
    @(negedge clk);
    bus.down_ready = 1'b0;
    applyStimulus(N'($urandom), SW'($urandom), 1'b0);
    applyStimulus(N'($urandom), SW'($urandom), 1'b0);
    @(posedge clk); #1;
    checkOutput("pre_rst_valid", N'(bus.down_valid), N'(1));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_down_valid", N'(bus.down_valid), '0);
    checkOutput("midrst_down_data", bus.down_data, 8'h00);
    checkOutput("midrst_up_ready", N'(bus.up_ready), N'(1));
    expQ.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.down_ready = 1'b1;
    startT = transfers;
    applyStimulus(8'h80, 3'd7, 1'b0);
    waitDrain();
    checkOutput("post_rst_transfers", N'(transfers - startT), N'(1));

`ifdef PVRS_ARITH_EN
    // Sign fill versus zero fill on the same word.
    applyStimulus(8'h90, 3'd2, 1'b1);
    applyStimulus(8'h90, 3'd2, 1'b0);
    waitDrain();
`endif

    // Randomised traffic with idle gaps and random consumer stalls.
    randReady = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
        bus.up_valid   = 1'b0;
        bus.down_ready = ($urandom_range(0, 3) != 0);
      end
      applyStimulus(N'($urandom), SW'($urandom),
                    ARITH ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    randReady = 1'b0;
    waitDrain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
